// File: rtl/fb_pixel_writer.sv
// ============================================================================
//  Module   : fb_pixel_writer
//  Purpose  : Buffers rasterizer pixel writes in a FIFO and merges pixels that
//             share a 16-bit framebuffer word into one nibble-masked write.
//             Optional macro FB_PIXEL_WRITER_CLIP_EN drops off-screen pixels.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_pixel_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int IDLE_FLUSH = 15
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        fb_we,
    input  logic [9:0]  fb_x,
    input  logic [9:0]  fb_y,
    input  logic [3:0]  data,
    output logic        fb_ready,
    input  logic        flush,
    output logic        flush_done,
    output logic        busy,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IDLE_FLUSH + 1);

    localparam logic [16:0]   c_WORDS_PER_ROW = 17'(FB_WIDTH / 4);
    localparam logic [AW:0]   c_DEPTH         = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_CNT_ONE       = (AW + 1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE       = AW'(1);
    localparam logic [CW-1:0] c_IDLE_LAST     = CW'(IDLE_FLUSH - 1);
    localparam logic [CW-1:0] c_IDLE_ONE      = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input side: address translation and optional clipping
    // ------------------------------------------------------------------
    logic [16:0] w_in_addr;
    logic        w_in_range;
    logic        w_push;
    logic        w_pop;

    assign w_in_addr = 17'(fb_y) * c_WORDS_PER_ROW + 17'(fb_x[9:2]);

`ifdef FB_PIXEL_WRITER_CLIP_EN
    localparam logic [10:0] c_FB_W = 11'(FB_WIDTH);
    localparam logic [10:0] c_FB_H = 11'(FB_HEIGHT);
    assign w_in_range = ({1'b0, fb_x} < c_FB_W) && ({1'b0, fb_y} < c_FB_H);
`else
    assign w_in_range = 1'b1;
`endif

    // A clipped pixel still completes its handshake; it just never enters the FIFO.
    assign w_push = fb_we && fb_ready && w_in_range;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [16:0]   r_fifo_addr [FIFO_DEPTH];
    logic [1:0]    r_fifo_nib  [FIFO_DEPTH];
    logic [3:0]    r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          w_fifo_empty;

    logic [16:0]   w_head_addr;
    logic [15:0]   w_head_word;
    logic [15:0]   w_head_mask;
    logic [3:0]    w_head_be;

    assign w_fifo_empty = (r_count == '0);
    assign w_head_addr  = r_fifo_addr[r_rptr];
    assign w_head_word  = 16'(r_fifo_data[r_rptr]) << {r_fifo_nib[r_rptr], 2'b00};
    assign w_head_mask  = 16'h000F << {r_fifo_nib[r_rptr], 2'b00};
    assign w_head_be    = 4'b0001 << r_fifo_nib[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_in_addr;
            r_fifo_nib[r_wptr]  <= fb_x[1:0];
            r_fifo_data[r_wptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            fb_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count  <= w_count_nxt;
            fb_ready <= (w_count_nxt != c_DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Combiner FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_idle_cnt;
    logic          r_flush_pending;
    logic          w_flush_req;
    logic          w_cmb_busy_nxt;
    logic          w_done_now;

    assign w_flush_req = r_flush_pending || flush;
    assign w_done_now  = r_flush_pending && w_fifo_empty && (r_state == S_IDLE);

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_fifo_empty;
            S_ACCUM: w_pop = !w_fifo_empty && (w_head_addr == mem_addr);
            default: w_pop = 1'b0;
        endcase
    end

    // Combiner still holds a word after this edge unless it is idle and not
    // loading, or its write is being accepted right now.
    assign w_cmb_busy_nxt = ((r_state == S_IDLE) && w_pop)
                          || (r_state == S_ACCUM)
                          || ((r_state == S_WRITE) && !mem_ack);

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state         <= S_IDLE;
            r_idle_cnt      <= '0;
            r_flush_pending <= 1'b0;
            flush_done      <= 1'b0;
            busy            <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_be          <= '0;
        end else begin
            flush_done <= 1'b0;
            busy       <= (w_count_nxt != '0) || w_cmb_busy_nxt;

            if (w_done_now) begin
                flush_done      <= 1'b1;
                r_flush_pending <= 1'b0;
            end else if (flush) begin
                r_flush_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        mem_addr   <= w_head_addr;
                        mem_wdata  <= w_head_word;
                        mem_be     <= w_head_be;
                        r_idle_cnt <= '0;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!w_fifo_empty) begin
                        if (w_head_addr == mem_addr) begin
                            // Later pixel to the same nibble overwrites the earlier one.
                            mem_wdata  <= (mem_wdata & ~w_head_mask) | w_head_word;
                            mem_be     <= mem_be | w_head_be;
                            r_idle_cnt <= '0;
                        end else begin
                            mem_req <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end else if (w_flush_req || (r_idle_cnt == c_IDLE_LAST)) begin
                        mem_req    <= 1'b1;
                        r_idle_cnt <= '0;
                        r_state    <= S_WRITE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
